systolic_array_sequencer: RTL and testbench
===========================================

# systolic_array_sequencer

Control block for the N×N output-stationary systolic array built from `processing_element_module` tiles, where each PE computes a*b + c and forwards a and b. It captures two N×N operand matrices on `start`, clears the array, and drives the skewed operand wavefronts into the left edge (A rows) and top edge (B columns). It then flags when every PE holds its final dot product. The array, the PE interconnect and the result readout live outside this block.

## Interface
- N, 4, array dimension; legal range 2..8.
- W, 8, operand width; matches the PE datapath.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a new multiply; sampled only in IDLE.
- mat_a  input  N*N*W  matrix A, row-major: element A[i][k] at bits [(i*N+k)*W +: W]. Captured on accepted start.
- mat_b  input  N*N*W  matrix B, row-major: element B[k][j] at bits [(k*N+j)*W +: W]. Captured on accepted start.
- edge_a  output  N*W  left-edge feed; slice i drives the a input of PE(i,0).
- edge_b  output  N*W  top-edge feed; slice j drives the b input of PE(0,j).
- array_clr_n  output  1  active-low clear to all PE registers (rst/preset wiring is done at integration).
- busy  output  1  high from CLEAR through DONE.
- done  output  1  one-cycle pulse; the array outputs hold C = A×B.

## Operation
- **States:** IDLE → CLEAR → FEED → DONE → IDLE. Encoding is free; no other states.
- **IDLE**
  - start=1 latches mat_a and mat_b into internal operand registers.
  - The next state is CLEAR.
  - start=0 holds IDLE.
- **CLEAR**
  - Exactly one cycle. array_clr_n=0 for this cycle only.
  - The feed counter t is loaded with 0.
- **FEED**
  - Lasts 3N-2 cycles, with t = 0 .. 3N-3. t increments each cycle.
  - After the cycle with t=3N-3, the next state is DONE.
  - During the cycle with counter value t:
    - edge_a slice i = A[i][t-i] if 0 ≤ t-i < N, else 0.
    - edge_b slice j = B[t-j][j] if 0 ≤ t-j < N, else 0.
  - Zero padding is mandatory, because PEs accumulate every cycle.
- **DONE**
  - One cycle. done=1, and edge_a and edge_b are 0.
  - The next state is IDLE unconditionally.
- **Outputs outside FEED:** edge_a and edge_b = 0.
- **Arithmetic:** none in this block. Products and sums wrap modulo 2^W in the PEs. The sequencer never saturates or extends width.
- **start outside IDLE:** ignored, including in DONE. Operand registers are not updated while busy. A changing mat_a or mat_b mid-run has no effect.
- **Reset (rst=0), asynchronous, at any time including mid-FEED:**
  - state=IDLE, t=0, operand registers=0.
  - edge_a=0, edge_b=0, array_clr_n=1, busy=0, done=0.
  - The aborted run produces no done.
  - The next accepted start performs a full CLEAR, so stale PE contents are discarded.

## Timing
- Call the cycle in which start=1 is sampled in IDLE cycle 0. Then:
  - CLEAR is cycle 1.
  - FEED is cycles 2 .. 3N-1.
  - DONE is cycle 3N.
  - IDLE resumes at cycle 3N+1.
- **Latency:** start to done is 3N cycles (12 for N=4). Minimum start-to-start interval is 3N+1.
- edge_a and edge_b are registered outputs and are valid for the whole FEED cycle. They are glitch-free and change only on clk edges.
- PE(i,j) receives its k-th operand pair in FEED cycle t=k+i+j. The last pair reaches PE(N-1,N-1) at t=3N-3. That sum is registered on the edge ending that cycle, so the results are stable in DONE.
- busy rises on the edge entering CLEAR and falls on the edge leaving DONE.
- The counter is at least ceil(log2(3N-1)) bits. It does not wrap within a run.

## Test plan
- **Identity:** N=4, A=I, B[k][j]=4k+j+1, array modelled with PE tiles. The done pulse arrives at cycle 12, and C equals B (PE(3,3)=16).
- **Skew check:** A[i][k]=16i+k, B=0. In cycle t=3, edge_a = {slice0=3, slice1=0x12, slice2=0x21, slice3=0x30}. At t=0, slices 1..3 are 0. At t=9, all slices are 0.
- **Wrap:** A and B all 0x10, N=4. Every PE output is (4·256) mod 256 = 0x00. With A and B all 0x03, every PE output is 0x24.
- **start while busy:** pulse start at cycle 5 with different mat_a. There is no restart, done still arrives at cycle 12, and the result reflects the original operands.
- **Reset mid-FEED:** assert rst=0 at t=4. All outputs go to 0 immediately (asynchronous), array_clr_n goes to 1, and busy goes to 0. After release, a new start runs CLEAR and produces the correct product with no residue.
- **Back-to-back:** start held high continuously. Runs are accepted at cycles 0 and 13, array_clr_n pulses low at cycles 1 and 14, and done pulses at cycles 12 and 25.

Source files
------------

// File: rtl/systolic_array_sequencer_if.sv
// Operand capture and skewed edge-feed bundle between a requester and the systolic array sequencer.
// master drives start and the two operand matrices; slave returns edge feeds, array clear and status.
interface systolic_array_sequencer_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic             start;
  logic [N*N*W-1:0] mat_a;
  logic [N*N*W-1:0] mat_b;
  logic [N*W-1:0]   edge_a;
  logic [N*W-1:0]   edge_b;
  logic             array_clr_n;
  logic             busy;
  logic             done;

  modport master (
    output start, mat_a, mat_b,
    input  edge_a, edge_b, array_clr_n, busy, done
  );

  modport slave (
    input  start, mat_a, mat_b,
    output edge_a, edge_b, array_clr_n, busy, done
  );
endinterface

// File: rtl/systolic_array_sequencer.sv
// Captures A and B on start, clears the array, then feeds skewed zero-padded wavefronts for 3N-2 cycles.
// start-to-done is 3N cycles; start is ignored while busy, there is no stall input.
module systolic_array_sequencer #(
  parameter int N = 4,
  parameter int W = 8
) (
  input logic                    clk,
  input logic                    rst,
  systolic_array_sequencer_if.slave bus
);
  localparam int LAST = 3*N - 3;
  localparam int CW   = $clog2(3*N - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    t;
  logic [CW-1:0]    sel_t;
  logic [N*N*W-1:0] op_a;
  logic [N*N*W-1:0] op_b;
  logic [N*W-1:0]   edge_a_q;
  logic [N*W-1:0]   edge_b_q;
  logic [N*W-1:0]   feed_a;
  logic [N*W-1:0]   feed_b;
  logic             clr_n_q;
  logic             busy_q;
  logic             done_q;

  // Wavefront for the FEED cycle about to start: t=0 when leaving CLEAR, t+1 while feeding.
  always_comb begin
    sel_t  = (state == FEED) ? t + CW'(1) : '0;
    feed_a = '0;
    feed_b = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(sel_t) >= i && int'(sel_t) - i < N) begin
        feed_a[i*W +: W] = op_a[(i*N + int'(sel_t) - i)*W +: W];
        feed_b[i*W +: W] = op_b[((int'(sel_t) - i)*N + i)*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      t        <= '0;
      op_a     <= '0;
      op_b     <= '0;
      edge_a_q <= '0;
      edge_b_q <= '0;
      clr_n_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_a    <= bus.mat_a;
            op_b    <= bus.mat_b;
            clr_n_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          clr_n_q  <= 1'b1;
          t        <= '0;
          edge_a_q <= feed_a;
          edge_b_q <= feed_b;
          state    <= FEED;
        end
        FEED: begin
          if (t == CW'(LAST)) begin
            edge_a_q <= '0;
            edge_b_q <= '0;
            done_q   <= 1'b1;
            state    <= DONE;
          end else begin
            t        <= t + CW'(1);
            edge_a_q <= feed_a;
            edge_b_q <= feed_b;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          t      <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.edge_a      = edge_a_q;
  assign bus.edge_b      = edge_b_q;
  assign bus.array_clr_n = clr_n_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Bench for systolic_array_sequencer: cycle-level reference of the run timeline, a PE-grid model of the
// external array, and directed scenarios with hand-computed expectations.
module tb_systolic_array_sequencer;
  localparam int N = 4;
  localparam int W = 8;
  localparam int MW = N*N*W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rel = 0;

  systolic_array_sequencer_if #(.N(N), .W(W)) bus ();
  systolic_array_sequencer #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [MW-1:0] mk(input int kind, input int v);
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        case (kind)
          0: m[(r*N+c)*W +: W] = (r == c) ? W'(1) : W'(0);
          1: m[(r*N+c)*W +: W] = W'(r*N + c + 1);
          2: m[(r*N+c)*W +: W] = W'(16*r + c);
          default: m[(r*N+c)*W +: W] = W'(v);
        endcase
    return m;
  endfunction

  function automatic logic [W-1:0] mm(input logic [MW-1:0] a, input logic [MW-1:0] b, input int i, input int j);
    logic [W-1:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s = W'(s + a[(i*N+k)*W +: W] * b[(k*N+j)*W +: W]);
    return s;
  endfunction

  // Reference timeline: c counts cycles since the accepted start (1 = CLEAR, 3N = DONE).
  bit            run = 1'b0;
  int            c = 0;
  logic [MW-1:0] ma = '0;
  logic [MW-1:0] mb = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      run = 1'b0;
      c   = 0;
    end else if (!run) begin
      if (bus.start) begin
        run = 1'b1;
        c   = 1;
        ma  = bus.mat_a;
        mb  = bus.mat_b;
      end
    end else if (c == 3*N) begin
      run = 1'b0;
    end else begin
      c++;
    end
  end

  // External PE grid: each tile accumulates a*b and forwards a right and b down.
  logic [W-1:0] ga [N][N];
  logic [W-1:0] gb [N][N];
  logic [W-1:0] gc [N][N];
  logic [W-1:0] na [N][N];
  logic [W-1:0] nb [N][N];
  logic [W-1:0] nc [N][N];

  initial
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ga[i][j] = '0; gb[i][j] = '0; gc[i][j] = '0;
      end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        na[i][j] = (j == 0) ? bus.edge_a[i*W +: W] : ga[i][j-1];
        nb[i][j] = (i == 0) ? bus.edge_b[j*W +: W] : gb[i-1][j];
        nc[i][j] = W'(gc[i][j] + na[i][j] * nb[i][j]);
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ga[i][j] = bus.array_clr_n ? na[i][j] : '0;
        gb[i][j] = bus.array_clr_n ? nb[i][j] : '0;
        gc[i][j] = bus.array_clr_n ? nc[i][j] : '0;
      end
  end

  // Per-cycle compare against the reference timeline and, on done, against plain matrix product.
  always @(negedge clk) begin
    logic [N*W-1:0] ea;
    logic [N*W-1:0] eb;
    int             tt;
    int             bad_el;
    ea = '0;
    eb = '0;
    if (run && c >= 2 && c <= 3*N-1) begin
      tt = c - 2;
      for (int i = 0; i < N; i++)
        if (tt - i >= 0 && tt - i < N) begin
          ea[i*W +: W] = ma[(i*N + tt - i)*W +: W];
          eb[i*W +: W] = mb[((tt - i)*N + i)*W +: W];
        end
    end
    chk("edge_a", 64'(bus.edge_a), 64'(ea));
    chk("edge_b", 64'(bus.edge_b), 64'(eb));
    chk("array_clr_n", 64'(bus.array_clr_n), 64'(!(run && c == 1)));
    chk("busy", 64'(bus.busy), 64'(run));
    chk("done", 64'(bus.done), 64'(run && c == 3*N));
    if (run && c == 3*N) begin
      bad_el = 0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (gc[i][j] !== mm(ma, mb, i, j)) bad_el++;
      chk("result_C_bad_elems", 64'(bad_el), 64'(0));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    rel++;
  endtask

  task automatic start_op(input logic [MW-1:0] a, input logic [MW-1:0] b);
    step();
    bus.start = 1'b1;
    bus.mat_a = a;
    bus.mat_b = b;
    rel = 0;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_cyc);
    for (int k = 0; k < 40; k++) begin
      if (bus.done) break;
      step();
    end
    chk(name, 64'(rel), 64'(exp_cyc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, d1, d2, ndone, nbad;
    bus.start = 1'b0;
    bus.mat_a = '0;
    bus.mat_b = '0;
    @(posedge clk);
    #2;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_clr_n", 64'(bus.array_clr_n), 64'(1));
    chk("rst_edge_a", 64'(bus.edge_a), 64'(0));
    step();
    rst = 1'b1;
    step();

    // Identity: C must equal B, PE(3,3)=16.
    start_op(mk(0, 0), mk(1, 0));
    wait_done("id_done_cycle", 12);
    chk("id_pe33", 64'(gc[3][3]), 64'h10);
    chk("id_pe01", 64'(gc[0][1]), 64'h02);

    // Skew of the left edge.
    start_op(mk(2, 0), mk(3, 0));
    while (rel < 2) step();
    chk("skew_t0_edge_a", 64'(bus.edge_a), 64'h0);
    while (rel < 5) step();
    chk("skew_t3_edge_a", 64'(bus.edge_a), 64'h3021_1203);
    while (rel < 11) step();
    chk("skew_t9_edge_a", 64'(bus.edge_a), 64'h0);
    chk("skew_t9_edge_b", 64'(bus.edge_b), 64'h0);
    wait_done("skew_done_cycle", 12);

    // Wrap modulo 2^W inside the array.
    start_op(mk(3, 8'h10), mk(3, 8'h10));
    wait_done("wrap10_done_cycle", 12);
    chk("wrap10_pe00", 64'(gc[0][0]), 64'h00);
    chk("wrap10_pe33", 64'(gc[3][3]), 64'h00);

    // start while busy with different operands must be ignored.
    start_op(mk(3, 3), mk(3, 3));
    while (rel < 5) step();
    bus.start = 1'b1;
    bus.mat_a = mk(3, 8'h10);
    bus.mat_b = mk(3, 8'h10);
    step();
    bus.start = 1'b0;
    wait_done("busy_start_done_cycle", 12);
    nbad = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (gc[i][j] !== 8'h24) nbad++;
    chk("busy_start_not_0x24", 64'(nbad), 64'(0));

    // Asynchronous reset in the middle of FEED (t=4).
    start_op(mk(0, 0), mk(1, 0));
    while (rel < 6) step();
    rst = 1'b0;
    #1;
    chk("abort_edge_a", 64'(bus.edge_a), 64'h0);
    chk("abort_edge_b", 64'(bus.edge_b), 64'h0);
    chk("abort_clr_n", 64'(bus.array_clr_n), 64'h1);
    chk("abort_busy", 64'(bus.busy), 64'h0);
    chk("abort_done", 64'(bus.done), 64'h0);
    step();
    step();
    rst = 1'b1;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (bus.done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'(0));
    start_op(mk(2, 0), mk(0, 0));
    wait_done("post_abort_done_cycle", 12);
    chk("post_abort_pe32", 64'(gc[3][2]), 64'h32);
    chk("post_abort_pe00", 64'(gc[0][0]), 64'h00);

    // Back-to-back with start held high.
    step();
    bus.start = 1'b1;
    bus.mat_a = mk(3, 3);
    bus.mat_b = mk(1, 0);
    rel = 0;
    c1 = -1; c2 = -1; d1 = -1; d2 = -1;
    while (rel < 26) begin
      step();
      if (!bus.array_clr_n) begin
        if (c1 < 0) c1 = rel;
        else if (c2 < 0) c2 = rel;
      end
      if (bus.done) begin
        if (d1 < 0) d1 = rel;
        else if (d2 < 0) d2 = rel;
      end
    end
    bus.start = 1'b0;
    chk("b2b_clr1", 64'(c1), 64'(1));
    chk("b2b_clr2", 64'(c2), 64'(14));
    chk("b2b_done1", 64'(d1), 64'(12));
    chk("b2b_done2", 64'(d2), 64'(25));
    step();
    step();
    chk("b2b_idle_busy", 64'(bus.busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
